// File: rtl/pcpi_galois_coproc_if.sv
// PCPI bus between a picorv32 core (master) and a coprocessor (slave).
// Signal names follow the core's pcpi_* port names.
interface pcpi_galois_coproc_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  pcpi_valid;
  logic [31:0]           pcpi_insn;
  logic [DATA_WIDTH-1:0] pcpi_rs1;
  logic [DATA_WIDTH-1:0] pcpi_rs2;
  logic                  pcpi_wr;
  logic [DATA_WIDTH-1:0] pcpi_rd;
  logic                  pcpi_wait;
  logic                  pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/pcpi_galois_coproc.sv
// PCPI Galois-field coprocessor: field config, GF add, carry-less multiply,
// reduced GF multiply and integer multiply, one operand bit per cycle.
module pcpi_galois_coproc #(
  parameter int DATA_WIDTH = 32
) (
  input logic                clk,
  input logic                resetn,
  pcpi_galois_coproc_if.slave pcpi
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(PW);
  localparam logic [5:0]            M_RESET = 6'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] DW_WORD = DATA_WIDTH'(DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_REDUCE, S_DONE, S_COOL} state_t;
  typedef enum logic [1:0] {OP_CLMUL, OP_GFMUL, OP_MUL} op_t;

  state_t                state;
  op_t                   op;
  logic [5:0]            m;
  logic [DATA_WIDTH-1:0] poly;
  logic [PW-1:0]         a_sh;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         red_mod;
  logic [CW-1:0]         cnt;

  logic          rtype, dec_clmul, dec_gfadd, dec_gfmul, dec_mul, dec_cfg;
  logic [5:0]    cfg_m;
  logic [PW-1:0] add_term, mul_next, red_next, red_result, mask_m, modulus;
  logic          unused_insn;

  assign unused_insn = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

  always_comb begin
    rtype     = (pcpi.pcpi_insn[6:0] == 7'b0110011) && (pcpi.pcpi_insn[31:25] == 7'b0000100);
    dec_clmul = rtype && (pcpi.pcpi_insn[14:12] == 3'b000);
    dec_gfadd = rtype && (pcpi.pcpi_insn[14:12] == 3'b001);
    dec_gfmul = rtype && (pcpi.pcpi_insn[14:12] == 3'b010);
    dec_mul   = rtype && (pcpi.pcpi_insn[14:12] == 3'b100);
    dec_cfg   = (pcpi.pcpi_insn[6:0] == 7'b0100011) && (pcpi.pcpi_insn[14:12] == 3'b100);
    cfg_m     = ((pcpi.pcpi_rs1 == '0) || (pcpi.pcpi_rs1 > DW_WORD)) ? M_RESET
                                                                      : pcpi.pcpi_rs1[5:0];
    add_term   = b_reg[0] ? a_sh : '0;
    mul_next   = (op == OP_MUL) ? acc + add_term : acc ^ add_term;
    red_next   = acc[cnt] ? acc ^ red_mod : acc;
    mask_m     = (PW'(1) << m) - PW'(1);
    modulus    = (PW'(1) << m) | (PW'(poly) & mask_m);
    red_result = red_next & mask_m;
  end

  // Single FSM: operands latched on acceptance, the multiplier walks rs2 LSB
  // first, then GFMUL clears product bits from the top down to x^m using a
  // modulus register that slides right in step with the bit index.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state           <= S_IDLE;
      op              <= OP_CLMUL;
      m               <= M_RESET;
      poly            <= '0;
      a_sh            <= '0;
      b_reg           <= '0;
      acc             <= '0;
      red_mod         <= '0;
      cnt             <= '0;
      pcpi.pcpi_wr    <= 1'b0;
      pcpi.pcpi_rd    <= '0;
      pcpi.pcpi_wait  <= 1'b0;
      pcpi.pcpi_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pcpi.pcpi_valid) begin
            if (dec_gfadd) begin
              pcpi.pcpi_rd    <= pcpi.pcpi_rs1 ^ pcpi.pcpi_rs2;
              pcpi.pcpi_wr    <= 1'b1;
              pcpi.pcpi_wait  <= 1'b1;
              pcpi.pcpi_ready <= 1'b1;
              state           <= S_DONE;
            end else if (dec_cfg) begin
              m               <= cfg_m;
              poly            <= pcpi.pcpi_rs2;
              pcpi.pcpi_wr    <= 1'b0;
              pcpi.pcpi_wait  <= 1'b1;
              pcpi.pcpi_ready <= 1'b1;
              state           <= S_DONE;
            end else if (dec_clmul || dec_gfmul || dec_mul) begin
              op             <= dec_mul ? OP_MUL : (dec_gfmul ? OP_GFMUL : OP_CLMUL);
              a_sh           <= PW'(pcpi.pcpi_rs1);
              b_reg          <= pcpi.pcpi_rs2;
              acc            <= '0;
              cnt            <= '0;
              red_mod        <= modulus << (CW'(PW - 2) - CW'(m));
              pcpi.pcpi_wait <= 1'b1;
              state          <= S_MULT;
            end
          end
        end
        S_MULT: begin
          if (!pcpi.pcpi_valid) begin
            pcpi.pcpi_wait <= 1'b0;
            state          <= S_IDLE;
          end else begin
            acc   <= mul_next;
            a_sh  <= a_sh << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(DATA_WIDTH - 1)) begin
              if (op == OP_GFMUL) begin
                cnt   <= CW'(PW - 2);
                state <= S_REDUCE;
              end else begin
                pcpi.pcpi_rd    <= mul_next[DATA_WIDTH-1:0];
                pcpi.pcpi_wr    <= 1'b1;
                pcpi.pcpi_ready <= 1'b1;
                state           <= S_DONE;
              end
            end
          end
        end
        S_REDUCE: begin
          if (!pcpi.pcpi_valid) begin
            pcpi.pcpi_wait <= 1'b0;
            state          <= S_IDLE;
          end else begin
            acc     <= red_next;
            red_mod <= red_mod >> 1;
            cnt     <= cnt - CW'(1);
            if (cnt == CW'(m)) begin
              pcpi.pcpi_rd    <= red_result[DATA_WIDTH-1:0];
              pcpi.pcpi_wr    <= 1'b1;
              pcpi.pcpi_ready <= 1'b1;
              state           <= S_DONE;
            end
          end
        end
        S_DONE: begin
          pcpi.pcpi_wr    <= 1'b0;
          pcpi.pcpi_wait  <= 1'b0;
          pcpi.pcpi_ready <= 1'b0;
          state           <= S_COOL;
        end
        // The core still holds pcpi_valid here; never re-issue from it.
        S_COOL:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcpi_galois_coproc.sv
// Directed bench for pcpi_galois_coproc: results, latencies, handshake
// shape, abort, reset mid-operation and post-ready valid hold.
module tb_pcpi_galois_coproc;
  localparam int DW = 32;
  localparam logic [31:0] CFG   = 32'h0020c023;
  localparam logic [31:0] CLMUL = 32'h08000033;
  localparam logic [31:0] GFADD = 32'h08001033;
  localparam logic [31:0] GFMUL = 32'h08002033;
  localparam logic [31:0] UNK   = 32'h08003033;
  localparam logic [31:0] MUL   = 32'h08004033;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pcpi_galois_coproc_if #(.DATA_WIDTH(DW)) bus ();
  pcpi_galois_coproc #(.DATA_WIDTH(DW)) dut (.clk(clk), .resetn(resetn), .pcpi(bus));

  int testCount = 0;
  int failCount = 0;

  logic [31:0] rdOut;
  logic        wrOut;
  int          latency;
  bit          waitGap;
  bit          extraReady;
  bit          sawActivity;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one instruction in picorv32 style and waits (bounded) for ready.
  task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] rs1,
                               input logic [31:0] rs2, input bit holdExtra);
    bit done;
    done = 0; latency = 0; waitGap = 0; extraReady = 0; rdOut = '0; wrOut = 1'b0;
    @(negedge clk);
    bus.pcpi_valid = 1'b1; bus.pcpi_insn = insn; bus.pcpi_rs1 = rs1; bus.pcpi_rs2 = rs2;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.pcpi_rs1  = ~rs1;
        bus.pcpi_rs2  = rs2 ^ 32'h5a5a5a5a;
        bus.pcpi_insn = (insn == GFADD) ? MUL : GFADD;
      end
      if (!bus.pcpi_wait) waitGap = 1;
      if (bus.pcpi_ready) begin
        latency = k; rdOut = bus.pcpi_rd; wrOut = bus.pcpi_wr; done = 1;
        break;
      end
    end
    checkOutput("completed", 64'(done), 64'd1);
    if (holdExtra) begin
      bus.pcpi_insn = insn; bus.pcpi_rs1 = rs1; bus.pcpi_rs2 = rs2;
      @(negedge clk);
    end
    @(negedge clk);
    bus.pcpi_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.pcpi_ready) extraReady = 1;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] expRd, input logic expWr,
                       input int expLat);
    applyStimulus(insn, rs1, rs2, 1'b0);
    if (expWr) checkOutput({tag, " rd"}, 64'(rdOut), 64'(expRd));
    checkOutput({tag, " wr"}, 64'(wrOut), 64'(expWr));
    checkOutput({tag, " latency"}, 64'(latency), 64'(expLat));
    checkOutput({tag, " wait gap"}, 64'(waitGap), 64'd0);
    checkOutput({tag, " extra ready"}, 64'(extraReady), 64'd0);
  endtask

  // Holds valid for some cycles without waiting for ready, noting any handshake.
  task automatic holdValid(input logic [31:0] insn, input int cycles);
    sawActivity = 0;
    @(negedge clk);
    bus.pcpi_valid = 1'b1; bus.pcpi_insn = insn; bus.pcpi_rs1 = 32'hA; bus.pcpi_rs2 = 32'hE;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (bus.pcpi_ready) sawActivity = 1;
    end
  endtask

  initial begin
    resetn = 1'b1;
    bus.pcpi_valid = 1'b0; bus.pcpi_insn = '0; bus.pcpi_rs1 = '0; bus.pcpi_rs2 = '0;
    #23;
    checkOutput("reset wr", 64'(bus.pcpi_wr), 64'd0);
    checkOutput("reset rd", 64'(bus.pcpi_rd), 64'd0);
    checkOutput("reset wait", 64'(bus.pcpi_wait), 64'd0);
    checkOutput("reset ready", 64'(bus.pcpi_ready), 64'd0);
    @(negedge clk); resetn = 1'b0;

    runOp("cfg m4", CFG, 32'd4, 32'h19, 32'h0, 1'b0, 1);
    runOp("gfadd", GFADD, 32'h5, 32'hA, 32'hF, 1'b1, 1);
    runOp("clmul", CLMUL, 32'hA, 32'hE, 32'h6C, 1'b1, DW + 1);
    runOp("gfmul m4", GFMUL, 32'hA, 32'hE, 32'h8, 1'b1, DW + 1 + 63 - 4);
    runOp("gfmul m4 unmasked", GFMUL, 32'h10, 32'h1, 32'h9, 1'b1, DW + 1 + 63 - 4);
    runOp("mul small", MUL, 32'd3, 32'd4, 32'hC, 1'b1, DW + 1);
    runOp("mul max", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b1, DW + 1);
    runOp("clmul high", CLMUL, 32'h80000001, 32'h3, 32'h80000003, 1'b1, DW + 1);

    holdValid(UNK, 5);
    checkOutput("unknown ready", 64'(sawActivity), 64'd0);
    checkOutput("unknown wait", 64'(bus.pcpi_wait), 64'd0);
    @(negedge clk); bus.pcpi_valid = 1'b0;

    runOp("cfg aes", CFG, 32'd8, 32'h11B, 32'h0, 1'b0, 1);
    applyStimulus(GFMUL, 32'h57, 32'h83, 1'b1);
    checkOutput("gfmul aes rd", 64'(rdOut), 64'hC1);
    checkOutput("gfmul aes latency", 64'(latency), 64'(DW + 1 + 63 - 8));
    checkOutput("hold valid second ready", 64'(extraReady), 64'd0);

    runOp("cfg clamp", CFG, 32'd40, 32'h8D, 32'h0, 1'b0, 1);
    runOp("gfmul m32 poly", GFMUL, 32'h80000000, 32'h2, 32'h8D, 1'b1, DW + 1 + 31);

    holdValid(CLMUL, 5);
    checkOutput("abort busy wait", 64'(bus.pcpi_wait), 64'd1);
    @(negedge clk); bus.pcpi_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.pcpi_ready) sawActivity = 1;
    end
    checkOutput("abort no ready", 64'(sawActivity), 64'd0);
    checkOutput("abort wait low", 64'(bus.pcpi_wait), 64'd0);
    runOp("gfmul after abort", GFMUL, 32'h80000000, 32'h2, 32'h8D, 1'b1, DW + 1 + 31);

    holdValid(CLMUL, 6);
    @(negedge clk); resetn = 1'b1; bus.pcpi_valid = 1'b0;
    #1;
    checkOutput("midreset wait", 64'(bus.pcpi_wait), 64'd0);
    checkOutput("midreset ready", 64'(bus.pcpi_ready), 64'd0);
    checkOutput("midreset wr", 64'(bus.pcpi_wr), 64'd0);
    checkOutput("midreset rd", 64'(bus.pcpi_rd), 64'd0);
    @(negedge clk); resetn = 1'b0;
    runOp("gfmul post reset", GFMUL, 32'h80000001, 32'h3, 32'h80000003, 1'b1, DW + 1 + 31);
    runOp("gfmul poly cleared", GFMUL, 32'h80000000, 32'h2, 32'h0, 1'b1, DW + 1 + 31);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/pcpi_galois_coproc.md
Name: pcpi_galois_coproc

Overview:
- PCPI coprocessor attached to a picorv32 core (ENABLE_PCPI=1).
- Executes custom Galois-field instructions:
  - GF(2^m) field configuration
  - GF add (XOR)
  - carry-less multiply
  - GF multiply with polynomial reduction
  - plain integer multiply
- Drives pcpi_wr/pcpi_rd/pcpi_wait/pcpi_ready back to the core; the core stalls until pcpi_ready.

Parameters:
DATA_WIDTH, 32, operand/result width; maximum field degree m.

Ports:
clk  in  1  clock, rising-edge active
resetn  in  1  reset, asynchronous, active-high (1 = reset asserted)
pcpi_valid  in  1  core presents an unrecognised instruction
pcpi_insn  in  32  instruction word
pcpi_rs1  in  DATA_WIDTH  rs1 value
pcpi_rs2  in  DATA_WIDTH  rs2 value
pcpi_wr  out  1  write pcpi_rd to rd (valid with pcpi_ready)
pcpi_rd  out  DATA_WIDTH  result
pcpi_wait  out  1  instruction claimed, result pending
pcpi_ready  out  1  one-cycle completion pulse

Behaviour:
- Decode (only when pcpi_valid=1):
  - R-type ops require insn[6:0]=0110011 and insn[31:25]=0000100. Selection by insn[14:12]:
    - 000 CLMUL
    - 001 GFADD
    - 010 GFMUL
    - 100 MUL
  - CFG: insn[6:0]=0100011 and insn[14:12]=100 (store-format slot; imm/rd fields ignored).
  - Any other encoding is ignored: no wait, no ready. The core then traps as illegal.
- Field state registers:
  - width m (6 bits): reset = DATA_WIDTH.
  - poly (DATA_WIDTH bits): reset = 0.
- CFG:
  - m <= rs1[5:0]; if rs1 is 0 or > DATA_WIDTH, m <= DATA_WIDTH.
  - poly <= rs2. Bit m of poly (if present) is ignored; the x^m term is implicit.
  - pcpi_wr=0.
- GFADD: rd = rs1 ^ rs2.
- CLMUL:
  - Full 2*DATA_WIDTH-bit carry-less product of rs1 and rs2.
  - rd = low DATA_WIDTH bits, unreduced.
- GFMUL:
  - Carry-less product P, then for i from 2*DATA_WIDTH-2 down to m: if P[i]=1, P ^= ({x^m} | poly[m-1:0]) << (i-m).
  - rd = P[m-1:0], zero-extended.
  - Operands are not masked; bits >= m participate in the product before reduction.
- MUL: rd = low DATA_WIDTH bits of rs1*rs2 (sign-agnostic).
- Handshake and latency (cycle 0 = first cycle pcpi_valid is high with a recognised insn):
  - GFADD, CFG:
    - pcpi_wait=1 in cycle 1.
    - pcpi_ready=1 in cycle 1 for exactly one cycle.
  - CLMUL, MUL, GFMUL: iterative shift-and-add/xor, one operand bit per cycle.
    - pcpi_wait=1 from cycle 1 until ready.
    - pcpi_ready=1 in cycle DATA_WIDTH+1 for CLMUL/MUL.
    - GFMUL adds one reduction step per cycle: 2*DATA_WIDTH-1-m extra cycles, ready afterwards.
  - pcpi_wr and pcpi_rd are valid in the ready cycle. pcpi_rd holds its value until the next completion.
  - Operands are latched in cycle 0. Later changes on rs1/rs2/insn do not affect the result.
  - After a ready pulse, the block ignores pcpi_valid for one cycle (the core deasserts it then). No re-issue.
  - If pcpi_valid drops while busy, the operation aborts: wait=0, no ready. Field state is unchanged.
- Reset mid-operation:
  - Immediately clears pcpi_wait, pcpi_ready, pcpi_wr, and busy state.
  - pcpi_rd = 0.
  - m = DATA_WIDTH, poly = 0.
- Reset values of outputs: pcpi_wr=0, pcpi_rd=0, pcpi_wait=0, pcpi_ready=0.

Test Plan:
- Field config then GFADD:
  - CFG rs1=4, rs2=0x19 (insn 0x0020c023) -> ready pulse, pcpi_wr=0; m=4, poly=x^4+x^3+1.
  - Then GFADD rs1=0x5, rs2=0xA -> rd=0xF, wr=1, ready 1 cycle after valid.
- CLMUL rs1=0xA, rs2=0xE -> rd=0x6C after DATA_WIDTH+1 cycles, wait high throughout.
- GFMUL (after the CFG above) rs1=0xA, rs2=0xE -> rd=0x8.
  - GFMUL with m=DATA_WIDTH (reset state, poly=0) returns the low DATA_WIDTH product bits.
- MUL rs1=3, rs2=4 -> rd=0xC. MUL 0xFFFFFFFF*0xFFFFFFFF -> rd=0x00000001.
- Unknown funct3=011 with the same opcode/funct7 -> pcpi_wait and pcpi_ready stay 0.
- Robustness:
  - Assert resetn during a busy CLMUL -> outputs 0 immediately; the next CFG/GFMUL behaves from reset state.
  - Hold pcpi_valid one extra cycle after ready -> no second ready.
